// File: rtl/butterfly3_seq.sv
// Serial 4-point butterfly: loads four samples, computes sums/differences in one
// cycle, then streams the four results out with a valid/ready handshake.
module butterfly3_seq #(
  parameter int unsigned W    = 28,
  parameter int unsigned ROWS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic signed [W-1:0] i_data,
  output logic                o_valid,
  input  logic                o_ready,
  output logic signed [W-1:0] o_data,
  output logic [1:0]          o_idx,
  output logic                o_last
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RowW-1:0] RowMax = RowW'(ROWS - 1);

  typedef enum logic [1:0] {StLoad, StCalc, StSend} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [RowW-1:0]       row_q, row_d;
  logic signed [W-1:0]   s_q [4];
  logic signed [W-1:0]   r_q [4];
  logic                  s_we, r_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    s_we    = 1'b0;
    r_we    = 1'b0;
    // Abort wins over any handshake in the same cycle
    if (i_clr) begin
      state_d = StLoad;
      cnt_d   = '0;
      row_d   = '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (i_valid) begin
            s_we  = 1'b1;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = StCalc;
          end
        end
        StCalc: begin
          r_we    = 1'b1;
          state_d = StSend;
        end
        StSend: begin
          if (o_ready) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_d = StLoad;
              row_d   = (row_q == RowMax) ? '0 : row_q + RowW'(1);
            end
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      row_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        s_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      if (s_we) s_q[cnt_q] <= i_data;
      if (r_we) begin
        r_q[0] <= s_q[0] + s_q[3];
        r_q[1] <= s_q[1] + s_q[2];
        r_q[2] <= s_q[1] - s_q[2];
        r_q[3] <= s_q[0] - s_q[3];
      end
    end
  end

  // Input side decoded from state only, so it never waits on o_ready
  always_comb begin
    i_ready = (state_q == StLoad);
    o_valid = (state_q == StSend);
    o_data  = '0;
    o_idx   = '0;
    o_last  = 1'b0;
    if (state_q == StSend) begin
      o_data = r_q[cnt_q];
      o_idx  = cnt_q;
      o_last = (cnt_q == 2'd3) && (row_q == RowMax);
    end
  end

endmodule

// File: tb/tb_butterfly3_seq.sv
// Self-checking bench for butterfly3_seq: directed rows, random rows with
// backpressure, abort and asynchronous reset, checked against a simple model.
module tb_butterfly3_seq;

  localparam int unsigned W    = 28;
  localparam int unsigned ROWS = 4;

  logic                clk;
  logic                rst_n;
  logic                i_clr;
  logic                i_valid;
  logic                i_ready;
  logic [W-1:0]        i_data;
  logic                o_valid;
  logic                o_ready;
  logic [W-1:0]        o_data;
  logic [1:0]          o_idx;
  logic                o_last;

  int n_cmp = 0;
  int n_err = 0;
  int rowm  = 0;

  logic [W-1:0] smp  [4];
  logic [W-1:0] expv [4];

  butterfly3_seq #(.W(W), .ROWS(ROWS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (i_clr),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_idx   (o_idx),
    .o_last  (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: butterfly sums/differences, reduced modulo 2^W
  task automatic model();
    longint t [4];
    t[0] = longint'(smp[0]) + longint'(smp[3]);
    t[1] = longint'(smp[1]) + longint'(smp[2]);
    t[2] = longint'(smp[1]) - longint'(smp[2]);
    t[3] = longint'(smp[0]) - longint'(smp[3]);
    for (int i = 0; i < 4; i++) expv[i] = t[i][W-1:0];
  endtask

  // Called at a negedge while the DUT should be loading
  task automatic feed(input logic [W-1:0] d);
    chk("load_i_ready", i_ready, 1);
    chk("load_o_valid", o_valid, 0);
    i_valid = 1'b1;
    i_data  = d;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic drain(input int pct);
    int idx = 0;
    int cyc = 0;
    logic rdy;
    while (idx < 4 && cyc < 200) begin
      rdy = ($urandom_range(99) < pct);
      chk("send_o_valid", o_valid, 1);
      chk("send_i_ready", i_ready, 0);
      chk("send_o_idx", o_idx, idx);
      chk("send_o_data", o_data, expv[idx]);
      chk("send_o_last", o_last, (idx == 3) && (rowm == ROWS - 1));
      // Junk on the input side must be ignored while busy
      i_valid = 1'b1;
      i_data  = W'($urandom);
      o_ready = rdy;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    chk("drain_transfers", idx, 4);
    i_valid = 1'b0;
    o_ready = 1'b0;
    rowm = (rowm + 1) % ROWS;
    chk("post_i_ready", i_ready, 1);
    chk("post_o_valid", o_valid, 0);
  endtask

  task automatic run_row(input int pct);
    for (int i = 0; i < 4; i++) feed(smp[i]);
    chk("calc_i_ready", i_ready, 0);
    chk("calc_o_valid", o_valid, 0);
    @(negedge clk);
    drain(pct);
  endtask

  task automatic random_row(input int pct);
    for (int i = 0; i < 4; i++) smp[i] = W'($urandom);
    model();
    run_row(pct);
  endtask

  initial begin
    rst_n   = 1'b0;
    i_clr   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    o_ready = 1'b0;
    #12;
    chk("rst_i_ready", i_ready, 1);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_idx", o_idx, 0);
    chk("rst_o_last", o_last, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic row
    smp[0] = W'(10); smp[1] = W'(20); smp[2] = W'(30); smp[3] = W'(40);
    expv[0] = W'(50); expv[1] = W'(50); expv[2] = W'(-10); expv[3] = W'(-30);
    run_row(100);

    // Wraparound row
    smp[0] = 28'h7FFFFFF; smp[1] = '0; smp[2] = '0; smp[3] = W'(1);
    expv[0] = 28'h8000000; expv[1] = '0; expv[2] = '0; expv[3] = 28'h7FFFFFE;
    run_row(100);

    // Finish first block and a full second block under backpressure
    for (int r = 0; r < 2 + ROWS; r++) random_row((r % 2 == 0) ? 30 : 100);

    // Abort mid-row while the row counter is non-zero
    random_row(100);
    feed(W'($urandom));
    feed(W'($urandom));
    i_clr   = 1'b1;
    i_valid = 1'b1;
    i_data  = W'($urandom);
    @(negedge clk);
    i_clr   = 1'b0;
    i_valid = 1'b0;
    rowm    = 0;
    chk("clr_i_ready", i_ready, 1);
    chk("clr_o_valid", o_valid, 0);
    smp[0] = W'(1); smp[1] = W'(2); smp[2] = W'(3); smp[3] = W'(4);
    expv[0] = W'(5); expv[1] = W'(5); expv[2] = W'(-1); expv[3] = W'(-3);
    run_row(100);
    for (int r = 1; r < ROWS; r++) random_row(30);

    // Asynchronous reset while presenting result index 2
    random_row(100);
    for (int i = 0; i < 4; i++) smp[i] = W'($urandom);
    model();
    for (int i = 0; i < 4; i++) feed(smp[i]);
    @(negedge clk);
    o_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    o_ready = 1'b0;
    chk("pre_rst_o_idx", o_idx, 2);
    chk("pre_rst_o_data", o_data, expv[2]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_o_valid", o_valid, 0);
    chk("arst_i_ready", i_ready, 1);
    chk("arst_o_data", o_data, 0);
    chk("arst_o_idx", o_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rowm  = 0;
    for (int r = 0; r < ROWS; r++) random_row(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/butterfly3_seq.md
BUTTERFLY3_SEQ -- requirements
Module: butterfly3_seq

Interface
REQ-001 Parameter: W, 28, sample width in bits (two's complement).
REQ-002 Parameter: ROWS, 4, rows per transform block; legal range 1..64.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: i_clr  input  1  synchronous abort of the current block.
REQ-006 Port: i_valid  input  1  i_data is valid.
REQ-007 Port: i_ready  output  1  block accepts a sample this cycle.
REQ-008 Port: i_data  input  W  serial input sample, signed.
REQ-009 Port: o_valid  output  1  o_data is valid.
REQ-010 Port: o_ready  input  1  downstream accepts o_data this cycle.
REQ-011 Port: o_data  output  W  serial butterfly result, signed.
REQ-012 Port: o_idx  output  2  index (0..3) of the result currently on o_data.
REQ-013 Port: o_last  output  1  o_data is the final result of the block.

Function
REQ-014 Three-state FSM: LOAD, CALC, SEND.
REQ-015 LOAD: i_ready=1, o_valid=0; each cycle with i_valid=1 writes i_data into buffer slot s[cnt] and increments the 2-bit cnt.
REQ-016 LOAD->CALC on the cycle the sample with cnt=3 is accepted; cnt wraps to 0.
REQ-017 CALC (exactly one cycle): i_ready=0, o_valid=0; latch r0=s0+s3, r1=s1+s2, r2=s1-s2, r3=s0-s3 into the result registers; go to SEND.
REQ-018 Arithmetic: W-bit signed, results truncated modulo 2^W (wrap, no saturation, no widening).
REQ-019 SEND: o_valid=1, i_ready=0, o_data=r[cnt], o_idx=cnt; cnt increments only when o_valid and o_ready are both 1.
REQ-020 o_data, o_idx and o_last SHALL hold stable while o_valid=1 and o_ready=0.
REQ-021 SEND->LOAD on the transfer with cnt=3; the row counter (0..ROWS-1) increments and wraps to 0 after ROWS-1.
REQ-022 o_last=1 only in SEND with o_idx=3 and row counter=ROWS-1.
REQ-023 Latency: 4th sample accepted at edge N; o_valid=1 from the cycle after edge N+1; with o_ready held at 1, the four results transfer on edges N+2..N+5.
REQ-024 No overlap: input is stalled (i_ready=0) during CALC and SEND; i_valid in those states is ignored and nothing is written to the buffer.
REQ-025 The input handshake SHALL NOT depend combinationally on o_ready; i_ready is decoded from state only.
REQ-026 i_clr=1 (any state) at an edge: state=LOAD, cnt=0, row counter=0; buffer and result contents are don't-care; a sample presented in that cycle is discarded.
REQ-027 i_clr has priority over every handshake in the same cycle.

Reset
REQ-028 rst_n=0 asynchronously forces state=LOAD, cnt=0, row counter=0, result and buffer registers=0.
REQ-029 Output values during and after reset: i_ready=1, o_valid=0, o_data=0, o_idx=0, o_last=0.
REQ-030 Reset mid-block discards all partial input and pending output; after release the next accepted sample is slot 0 of row 0.

Verification
REQ-031 Basic: samples 10,20,30,40 with o_ready=1 -> o_data 50,50,-10,-30 with o_idx 0,1,2,3; o_valid is first seen 2 cycles after the 4th accept.
REQ-032 Wrap: samples 0x7FFFFFF,0,0,1 -> o_data 0x8000000 (-134217728), 0, 0, 0x7FFFFFE.
REQ-033 Backpressure: o_ready random at 30% -> o_data/o_idx stable while stalled; exactly 4 transfers per row; i_ready=0 until the 4th transfer completes.
REQ-034 Block framing, ROWS=4: 16 samples in -> 16 results out; o_last=1 only on the 16th; the next block's o_last is again on its 16th result.
REQ-035 Abort: i_clr pulsed after 2 accepted samples, then 4 new samples 1,2,3,4 -> outputs 5,5,-1,-3 with row counter restarted (o_last timing counts from this row).
REQ-036 Async reset in SEND with o_idx=2 -> o_valid=0 and i_ready=1 immediately, with no remaining results emitted; the next 4 samples are processed as row 0.
